ub_port_arbiter: RTL and testbench

- Parametrised N-requester arbiter in front of the unified buffer (UB) single port.
- Replaces the ad-hoc UART-over-legacy-DMA mux in the TPU top level.
- Requesters (UART DMA, legacy DMA, controller, future host ports) issue valid/ready read/write beats, optionally as locked bursts.
- Read data returns to the issuing requester after a fixed, parametrised UB latency. Fixed-priority or round-robin mode is selectable at runtime.

---
 rtl/ub_arb_pkg.sv | 19 +
 rtl/ub_port_arbiter_if.sv | 25 ++
 rtl/rr_picker.sv | 38 +++
 rtl/ub_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_ub_port_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ub_arb_pkg.sv
// Shared types and helpers for the unified-buffer port arbiter.
package ub_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Requester-id width; never below one bit so single-requester builds stay legal.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Low bit of element idx inside a packed vector of w-bit elements.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/ub_port_arbiter_if.sv
// Requester-side beat bus: valid/ready request channel plus shared read return.
interface ub_port_arbiter_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 256
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;

  modport master (
    output req_valid, req_we, req_last, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_last, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/rr_picker.sv
// One-hot winner selection: first valid at or after the start index, wrapping.
module rr_picker
  import ub_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned ID_W   = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  input  logic               fixed,
  output logic [NUM_REQ-1:0] grant
);

  logic [ID_W-1:0]    start;
  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] rot_grant;
  logic               found;

  // Fixed priority is round-robin anchored at index 0.
  assign start = fixed ? '0 : ptr;
  assign rot   = NUM_REQ'({valid, valid} >> start);

  // Lowest set bit of the rotated request vector.
  always_comb begin
    rot_grant = '0;
    found     = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!found && rot[j]) begin
        rot_grant[j] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  // Rotate the grant back into requester order.
  assign grant = NUM_REQ'(({rot_grant, rot_grant} << start) >> NUM_REQ);

endmodule

// File: rtl/ub_port_arbiter.sv
// N-requester arbiter in front of the UB single port with burst locking and read return.
module ub_port_arbiter
  import ub_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned LOCK_TMO  = 32,
  localparam int unsigned ID_W     = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prio_mode,
  ub_port_arbiter_if.slave   req_if,
  output logic               ub_wr_en,
  output logic [ADDR_W-1:0]  ub_wr_addr,
  output logic [DATA_W-1:0]  ub_wr_data,
  output logic               ub_rd_en,
  output logic [ADDR_W-1:0]  ub_rd_addr,
  input  logic [DATA_W-1:0]  ub_rd_data,
  output logic [ID_W-1:0]    owner_id,
  output logic               locked,
  output logic               burst_trunc,
  output logic               lock_abort
);

  localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);
  localparam int unsigned TMO_W  = $clog2(LOCK_TMO + 1);

  arb_state_e               state_q, state_d;
  logic [ID_W-1:0]          ptr_q, ptr_d;
  logic [ID_W-1:0]          owner_q, owner_d;
  logic [BEAT_W-1:0]        beat_q, beat_d, beat_inc;
  logic [TMO_W-1:0]         tmo_q, tmo_d, tmo_inc;
  logic [NUM_REQ-1:0]       pick_grant;
  logic [NUM_REQ-1:0]       cand;
  logic                     accept;
  logic [ID_W-1:0]          sel_id;
  logic                     sel_we;
  logic                     sel_last;
  logic [ADDR_W-1:0]        sel_addr;
  logic [DATA_W-1:0]        sel_wdata;
  logic [RD_LAT-1:0]        pipe_vld_q;
  logic [RD_LAT-1:0][ID_W-1:0] pipe_id_q;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
    return (32'(id) >= NUM_REQ - 1) ? '0 : id + ID_W'(1);
  endfunction

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .valid (req_if.req_valid),
    .ptr   (ptr_q),
    .fixed (prio_mode),
    .grant (pick_grant)
  );

  // Beat granted this cycle: picker winner when idle, only the owner when locked.
  always_comb begin
    cand = '0;
    if (!rst) begin
      if (state_q == LOCKED) cand = req_if.req_valid & (NUM_REQ'(1) << owner_q);
      else                   cand = pick_grant;
    end
  end

  assign accept = |cand;

  // Mux the granted requester's beat fields.
  always_comb begin
    sel_id    = '0;
    sel_we    = 1'b0;
    sel_last  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (cand[i]) begin
        sel_id    = ID_W'(i);
        sel_we    = req_if.req_we[i];
        sel_last  = req_if.req_last[i];
        sel_addr  = req_if.req_addr[slice_lo(i, ADDR_W) +: ADDR_W];
        sel_wdata = req_if.req_wdata[slice_lo(i, DATA_W) +: DATA_W];
      end
    end
  end

  assign beat_inc = beat_q + BEAT_W'(1);
  assign tmo_inc  = tmo_q + TMO_W'(1);

  // Lock FSM next state, pointer/counter updates and release pulses.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    beat_d      = beat_q;
    tmo_d       = tmo_q;
    burst_trunc = 1'b0;
    lock_abort  = 1'b0;
    if (accept) owner_d = sel_id;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (sel_last) begin
            ptr_d = wrap_inc(sel_id);
          end else if (MAX_BURST > 1) begin
            state_d = LOCKED;
            beat_d  = BEAT_W'(1);
            tmo_d   = '0;
          end else begin
            burst_trunc = 1'b1;
            ptr_d       = wrap_inc(sel_id);
          end
        end
      end
      LOCKED: begin
        if (accept) begin
          beat_d = beat_inc;
          tmo_d  = '0;
          if (sel_last || beat_inc == BEAT_W'(MAX_BURST)) begin
            burst_trunc = !sel_last;
            state_d     = IDLE;
            ptr_d       = wrap_inc(owner_q);
            beat_d      = '0;
          end
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TMO_W'(LOCK_TMO)) begin
            lock_abort = 1'b1;
            state_d    = IDLE;
            ptr_d      = wrap_inc(owner_q);
            beat_d     = '0;
            tmo_d      = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      beat_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
    end
  end

  // Read-return tracker: {valid, id} delayed by the UB read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q <= '0;
      pipe_id_q  <= '0;
    end else begin
      pipe_vld_q[0] <= accept & ~sel_we;
      pipe_id_q[0]  <= sel_id;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_id_q[i]  <= pipe_id_q[i-1];
      end
    end
  end

  assign req_if.req_ready = cand;
  assign ub_wr_en         = accept & sel_we;
  assign ub_rd_en         = accept & ~sel_we;
  assign ub_wr_addr       = ub_wr_en ? sel_addr : '0;
  assign ub_wr_data       = ub_wr_en ? sel_wdata : '0;
  assign ub_rd_addr       = ub_rd_en ? sel_addr : '0;
  assign req_if.rsp_valid = pipe_vld_q[RD_LAT-1] ? (NUM_REQ'(1) << pipe_id_q[RD_LAT-1]) : '0;
  assign req_if.rsp_rdata = pipe_vld_q[RD_LAT-1] ? ub_rd_data : '0;
  assign owner_id         = owner_q;
  assign locked           = (state_q == LOCKED);

endmodule

// File: tb/tb_ub_port_arbiter.sv
// Self-checking bench for ub_port_arbiter: vector table, corner sequences, random vs model.
module tb_ub_port_arbiter;

  localparam int unsigned N    = 3;
  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 256;
  localparam int unsigned LAT  = 1;
  localparam int unsigned MB   = 16;
  localparam int unsigned TMO  = 32;
  localparam int unsigned LAT2 = 3;

  logic clk = 1'b0;
  logic rst, rst2, prio_mode, prio2;
  always #5 clk = ~clk;

  ub_port_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
  ub_port_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus2 ();

  logic          ub_wr_en, ub_rd_en, locked, burst_trunc, lock_abort;
  logic [AW-1:0] ub_wr_addr, ub_rd_addr;
  logic [DW-1:0] ub_wr_data, ub_rd_data;
  logic [1:0]    owner_id;

  logic          wr_en2, rd_en2, locked2, trunc2, abort2;
  logic [AW-1:0] wr_addr2, rd_addr2;
  logic [DW-1:0] wr_data2, rd_data2;
  logic [1:0]    owner2;

  ub_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT),
                    .MAX_BURST(MB), .LOCK_TMO(TMO)) dut (
    .clk(clk), .rst(rst), .prio_mode(prio_mode), .req_if(bus.slave),
    .ub_wr_en(ub_wr_en), .ub_wr_addr(ub_wr_addr), .ub_wr_data(ub_wr_data),
    .ub_rd_en(ub_rd_en), .ub_rd_addr(ub_rd_addr), .ub_rd_data(ub_rd_data),
    .owner_id(owner_id), .locked(locked), .burst_trunc(burst_trunc), .lock_abort(lock_abort)
  );

  ub_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT2),
                    .MAX_BURST(MB), .LOCK_TMO(TMO)) dut2 (
    .clk(clk), .rst(rst2), .prio_mode(prio2), .req_if(bus2.slave),
    .ub_wr_en(wr_en2), .ub_wr_addr(wr_addr2), .ub_wr_data(wr_data2),
    .ub_rd_en(rd_en2), .ub_rd_addr(rd_addr2), .ub_rd_data(rd_data2),
    .owner_id(owner2), .locked(locked2), .burst_trunc(trunc2), .lock_abort(abort2)
  );

  assign rd_data2 = {8{32'h1234_5678}};

  // UB memory: contents are a fixed function of the address.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {8{a, 8'h3C, ~a, 8'hA5}};
  endfunction

  logic          rdv;
  logic [AW-1:0] rda;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rdv <= 1'b0;
      rda <= '0;
    end else begin
      rdv <= ub_rd_en;
      rda <= ub_rd_addr;
    end
  end
  assign ub_rd_data = rdv ? mem_word(rda) : {8{32'hDEAD_BEEF}};

  // Reference model state (integer view of the arbitration rules).
  typedef struct {
    int          due;
    int          id;
    logic [AW-1:0] addr;
  } rd_t;
  rd_t rq[$];
  int  m_owner, m_ptr, m_beats, m_idle, m_last_id, cyc;
  int  n_chk, n_pass;

  logic [N-1:0] s_ready;
  logic         s_locked, s_trunc, s_abort, s_wr;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
  endtask

  task automatic set_req(input int i, input logic v, input logic w, input logic l);
    bus.req_valid[i] = v;
    bus.req_we[i]    = w;
    bus.req_last[i]  = l;
    bus.req_addr[i*AW +: AW]  = AW'($urandom);
    bus.req_wdata[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom,
                                 $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic set_all(input logic [N-1:0] v, input logic [N-1:0] w, input logic [N-1:0] l);
    for (int i = 0; i < N; i++) set_req(i, v[i], w[i], l[i]);
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_beats = 0; m_idle = 0; m_last_id = 0; cyc = 0;
    rq.delete();
  endtask

  // One cycle: predict from the model, compare mid-cycle, then advance.
  task automatic step();
    int            acc;
    logic [N-1:0]  e_ready, e_rspv;
    logic [DW-1:0] e_rspd, e_wd;
    logic [AW-1:0] e_addr;
    logic          e_trunc, e_abort, e_locked, e_wr, e_rd;
    logic [1:0]    e_owner;
    @(negedge clk);
    e_locked = (m_owner >= 0);
    e_owner  = 2'(m_last_id);
    e_rspv   = '0;
    e_rspd   = '0;
    if (rq.size() != 0 && rq[0].due == cyc) begin
      e_rspv = N'(1) << rq[0].id;
      e_rspd = mem_word(rq[0].addr);
      void'(rq.pop_front());
    end
    acc = -1; e_trunc = 1'b0; e_abort = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int r;
        r = prio_mode ? k : (m_ptr + k) % N;
        if (acc < 0 && bus.req_valid[r]) acc = r;
      end
      if (acc >= 0) begin
        if (bus.req_last[acc]) m_ptr = (acc + 1) % N;
        else begin m_owner = acc; m_beats = 1; m_idle = 0; end
      end
    end else if (bus.req_valid[m_owner]) begin
      acc = m_owner;
      m_beats++;
      m_idle = 0;
      if (bus.req_last[acc] || m_beats == MB) begin
        e_trunc = !bus.req_last[acc];
        m_ptr   = (acc + 1) % N;
        m_owner = -1;
      end
    end else begin
      m_idle++;
      if (m_idle == TMO) begin
        e_abort = 1'b1;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
    e_ready = '0; e_wr = 1'b0; e_rd = 1'b0; e_addr = '0; e_wd = '0;
    if (acc >= 0) begin
      e_ready   = N'(1) << acc;
      e_wr      = bus.req_we[acc];
      e_rd      = !bus.req_we[acc];
      e_addr    = bus.req_addr[acc*AW +: AW];
      e_wd      = e_wr ? bus.req_wdata[acc*DW +: DW] : '0;
      m_last_id = acc;
      if (e_rd) rq.push_back('{cyc + LAT, acc, e_addr});
    end
    chk("ready",     DW'(bus.req_ready),  DW'(e_ready));
    chk("wr_en",     DW'(ub_wr_en),       DW'(e_wr));
    chk("wr_addr",   DW'(ub_wr_addr),     DW'(e_wr ? e_addr : '0));
    chk("wr_data",   ub_wr_data,          e_wd);
    chk("rd_en",     DW'(ub_rd_en),       DW'(e_rd));
    chk("rd_addr",   DW'(ub_rd_addr),     DW'(e_rd ? e_addr : '0));
    chk("rsp_valid", DW'(bus.rsp_valid),  DW'(e_rspv));
    chk("rsp_rdata", bus.rsp_rdata,       e_rspd);
    chk("owner_id",  DW'(owner_id),       DW'(e_owner));
    chk("locked",    DW'(locked),         DW'(e_locked));
    chk("trunc",     DW'(burst_trunc),    DW'(e_trunc));
    chk("abort",     DW'(lock_abort),     DW'(e_abort));
    s_ready  = bus.req_ready;
    s_locked = locked;
    s_trunc  = burst_trunc;
    s_abort  = lock_abort;
    s_wr     = ub_wr_en;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         prio;
    logic [N-1:0] v;
    logic [N-1:0] we;
    logic [N-1:0] exp_ready;
  } row_t;
  row_t tbl[10];

  initial begin
    n_chk = 0; n_pass = 0;
    model_reset();
    tbl[0] = '{1'b0, 3'b101, 3'b000, 3'b001};
    tbl[1] = '{1'b0, 3'b101, 3'b000, 3'b100};
    tbl[2] = '{1'b0, 3'b111, 3'b010, 3'b001};
    tbl[3] = '{1'b0, 3'b111, 3'b101, 3'b010};
    tbl[4] = '{1'b0, 3'b011, 3'b011, 3'b001};
    tbl[5] = '{1'b1, 3'b110, 3'b100, 3'b010};
    tbl[6] = '{1'b1, 3'b111, 3'b111, 3'b001};
    tbl[7] = '{1'b0, 3'b000, 3'b000, 3'b000};
    tbl[8] = '{1'b0, 3'b100, 3'b000, 3'b100};
    tbl[9] = '{1'b1, 3'b100, 3'b100, 3'b100};

    // Reset with all requesters active: every output must stay at zero.
    rst = 1'b1; rst2 = 1'b1; prio_mode = 1'b0; prio2 = 1'b0;
    set_all(3'b111, 3'b000, 3'b111);
    bus2.req_valid = '0; bus2.req_we = '0; bus2.req_last = '0;
    bus2.req_addr = '0; bus2.req_wdata = '0;
    #12;
    chk("rst_ready",  DW'(bus.req_ready), '0);
    chk("rst_rd_en",  DW'(ub_rd_en),      '0);
    chk("rst_rdaddr", DW'(ub_rd_addr),    '0);
    chk("rst_rsp",    DW'(bus.rsp_valid), '0);
    chk("rst_owner",  DW'(owner_id),      '0);
    chk("rst_locked", DW'(locked),        '0);
    set_all(3'b000, 3'b000, 3'b111);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Single-beat arbitration vectors, pointer starting at 0.
    for (int i = 0; i < 10; i++) begin
      prio_mode = tbl[i].prio;
      set_all(tbl[i].v, tbl[i].we, 3'b111);
      step();
      chk("tbl_ready", DW'(s_ready), DW'(tbl[i].exp_ready));
    end

    // Fixed priority, everyone streaming writes: req0 starves the rest.
    prio_mode = 1'b1;
    for (int c = 0; c < 6; c++) begin
      set_all(3'b111, 3'b111, 3'b111);
      step();
      chk("fix_ready", DW'(s_ready), DW'(3'b001));
      chk("fix_wr",    DW'(s_wr),    DW'(1'b1));
    end

    // Four-beat write burst from req1 while req0 waits.
    prio_mode = 1'b0;
    for (int b = 0; b < 4; b++) begin
      set_req(0, 1'b1, 1'b0, 1'b1);
      set_req(1, 1'b1, 1'b1, 1'(b == 3));
      set_req(2, 1'b0, 1'b0, 1'b1);
      step();
      chk("burst_ready",  DW'(s_ready),  DW'(3'b010));
      chk("burst_locked", DW'(s_locked), DW'(b > 0));
    end
    set_all(3'b001, 3'b000, 3'b111);
    step();
    chk("after_burst", DW'(s_ready), DW'(3'b001));

    // Sixteen non-last beats force a truncating release.
    prio_mode = 1'b1;
    for (int b = 0; b < 16; b++) begin
      set_all(3'b010, 3'b010, 3'b000);
      step();
      chk("trunc_pulse", DW'(s_trunc), DW'(b == 15));
    end
    prio_mode = 1'b0;
    set_all(3'b111, 3'b000, 3'b111);
    step();
    chk("trunc_ptr",    DW'(s_ready),  DW'(3'b100));
    chk("trunc_unlock", DW'(s_locked), DW'(1'b0));

    // Owner req2 goes silent inside its lock; req0 waits out the timeout.
    set_all(3'b100, 3'b100, 3'b000);
    step();
    chk("tmo_lock", DW'(s_ready), DW'(3'b100));
    for (int k = 0; k < 32; k++) begin
      set_all(3'b001, 3'b001, 3'b111);
      step();
      chk("tmo_ready", DW'(s_ready), DW'(3'b000));
      chk("tmo_abort", DW'(s_abort), DW'(k == 31));
    end
    set_all(3'b001, 3'b001, 3'b111);
    step();
    chk("tmo_next", DW'(s_ready), DW'(3'b001));

    // Randomised traffic against the model.
    for (int c = 0; c < 400; c++) begin
      if (c % 25 == 0) prio_mode = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 2) == 0));
      step();
    end
    for (int c = 0; c < 4; c++) begin
      set_all(3'b000, 3'b000, 3'b111);
      step();
    end

    // Reset while a read is in flight (latency 3): nothing may return afterwards.
    @(negedge clk) rst2 = 1'b0;
    @(posedge clk);
    #1;
    bus2.req_valid = 3'b100; bus2.req_we = 3'b000; bus2.req_last = 3'b000;
    bus2.req_addr  = {8'h5A, 8'h11, 8'h22};
    @(posedge clk);
    #1;
    bus2.req_valid = 3'b000;
    @(posedge clk);
    #1;
    chk("f_locked_pre", DW'(locked2), DW'(1'b1));
    chk("f_owner_pre",  DW'(owner2),  DW'(2'd2));
    bus2.req_valid = 3'b111; bus2.req_last = 3'b111;
    #2 rst2 = 1'b1;
    #1;
    chk("f_rst_ready",  DW'(bus2.req_ready), '0);
    chk("f_rst_rd_en",  DW'(rd_en2),         '0);
    chk("f_rst_rdaddr", DW'(rd_addr2),       '0);
    chk("f_rst_rsp",    DW'(bus2.rsp_valid), '0);
    chk("f_rst_rdata",  bus2.rsp_rdata,      '0);
    chk("f_rst_owner",  DW'(owner2),         '0);
    chk("f_rst_locked", DW'(locked2),        '0);
    bus2.req_valid = 3'b000;
    @(negedge clk) rst2 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("f_no_rsp",   DW'(bus2.rsp_valid), '0);
      chk("f_no_rdata", bus2.rsp_rdata,      '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
